// File: rtl/pwm_bridge_gen.sv
// pwm_bridge_gen: multi-leg half-bridge PWM generator.
// Symmetric triangular carrier, per-leg compare flags feeding saturating
// dead-time integrators, and a registered gate stage selecting between
// RUN, CHECK (sequenced gate self-test), BYPASS (timed or forced) and OFF.
// Optional feature macro: PWM_SHADOW_EN -- when defined, fre/duty are
// latched into shadow registers on syn and at each carrier valley, and
// the carrier/compare/RUN logic uses only the shadow copies.
module pwm_bridge_gen #(
    parameter int CW       = 16,
    parameter int NLEG     = 2,
    parameter int DT       = 280,
    parameter int DTW      = 10,
    parameter int CHK_SLOT = 10000,
    parameter int CHK_ON   = 9500,
    parameter int BYP      = 20000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 syn,
    input  logic                 start,
    input  logic                 check,
    input  logic                 pass,
    input  logic [CW-1:0]        fre,
    input  logic [NLEG*CW-1:0]   duty,
    input  logic                 fault,
    input  logic [NLEG-1:0]      leg_fault,
    input  logic [2*NLEG-1:0]    col,
    output logic [2*NLEG-1:0]    gate,
    output logic [CW-1:0]        comp_tri,
    output logic                 dir,
    output logic [CW-1:0]        check_data
);

    localparam int BW = $clog2(BYP + 1);

    localparam logic [CW-1:0]  ONE     = CW'(1);
    localparam logic [CW-1:0]  CHK_SAT = CW'(2 * NLEG * CHK_SLOT);
    localparam logic [DTW-1:0] DT_MAX  = DTW'(DT);
    localparam logic [DTW-1:0] DT_ONE  = DTW'(1);
    localparam logic [BW-1:0]  BYP_MAX = BW'(BYP);
    localparam logic [BW-1:0]  BYP_ONE = BW'(1);

    typedef enum logic [1:0] {
        MODE_OFF,
        MODE_RUN,
        MODE_CHECK,
        MODE_BYPASS
    } mode_t;

    logic [CW-1:0]      fre_eff;
    logic [NLEG*CW-1:0] duty_eff;
    logic [CW-1:0]      duty_w [NLEG];
    logic [CW-1:0]      fre_half;
    logic [CW-1:0]      tri_half;
    logic [NLEG-1:0]    pa;
    logic [DTW-1:0]     dcnt [NLEG];
    logic [BW-1:0]      byp_cnt;
    logic               byp_active;
    logic               duty_all_nz;
    mode_t              mode;
    logic [2*NLEG-1:0]  gate_nxt;

`ifdef PWM_SHADOW_EN
    logic [CW-1:0]      fre_sh;
    logic [NLEG*CW-1:0] duty_sh;

    // Shadow load on resync or at the valley turn of the carrier
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fre_sh  <= '0;
            duty_sh <= '0;
        end else if (syn || (!dir && comp_tri == '0)) begin
            fre_sh  <= fre;
            duty_sh <= duty;
        end
    end

    assign fre_eff  = fre_sh;
    assign duty_eff = duty_sh;
`else
    assign fre_eff  = fre;
    assign duty_eff = duty;
`endif

    // Split the packed duty bus into per-leg compare words
    always_comb begin
        for (int unsigned i = 0; i < NLEG; i++) begin
            duty_w[i] = duty_eff[i*CW +: CW];
        end
    end

    // Compare operands: half carrier peak and half carrier count
    always_comb begin
        fre_half = fre_eff >> 1;
        tri_half = comp_tri >> 1;
    end

    // Triangular carrier: 0 -> fre -> 0, resync forces restart at 0 going up
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            comp_tri <= '0;
            dir      <= 1'b1;
        end else if (syn || fre_eff == '0) begin
            comp_tri <= '0;
            dir      <= 1'b1;
        end else if (dir) begin
            if (comp_tri == fre_eff) begin
                dir      <= 1'b0;
                comp_tri <= fre_eff - ONE;
            end else begin
                comp_tri <= comp_tri + ONE;
            end
        end else begin
            if (comp_tri == '0) begin
                dir      <= 1'b1;
                comp_tri <= ONE;
            end else begin
                comp_tri <= comp_tri - ONE;
            end
        end
    end

    // Per-leg compare flag: set on the up slope, cleared on the down slope
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pa <= '0;
        end else begin
            for (int unsigned i = 0; i < NLEG; i++) begin
                if (duty_w[i] >= fre_half) begin
                    pa[i] <= 1'b0;
                end else if (dir && tri_half > duty_w[i]) begin
                    pa[i] <= 1'b1;
                end else if (!dir && tri_half < duty_w[i]) begin
                    pa[i] <= 1'b0;
                end
            end
        end
    end

    // Dead-time integrators, saturating at 0 and DT, running in every mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NLEG; i++) begin
                dcnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NLEG; i++) begin
                if (pa[i]) begin
                    if (dcnt[i] != DT_MAX) begin
                        dcnt[i] <= dcnt[i] + DT_ONE;
                    end
                end else if (dcnt[i] != '0) begin
                    dcnt[i] <= dcnt[i] - DT_ONE;
                end
            end
        end
    end

    // Self-check timer: counts while check is held, saturates at the last slot end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            check_data <= '0;
        end else if (!check) begin
            check_data <= '0;
        end else if (check_data != CHK_SAT) begin
            check_data <= check_data + ONE;
        end
    end

    // Bypass timer: counts while fault is held, saturates at BYP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp_cnt <= '0;
        end else if (!fault) begin
            byp_cnt <= '0;
        end else if (byp_cnt != BYP_MAX) begin
            byp_cnt <= byp_cnt + BYP_ONE;
        end
    end

    // Mode selection in priority order RUN > CHECK > BYPASS > OFF
    always_comb begin
        duty_all_nz = 1'b1;
        for (int unsigned i = 0; i < NLEG; i++) begin
            if (duty_w[i] == '0) begin
                duty_all_nz = 1'b0;
            end
        end
        byp_active = pass || (byp_cnt != '0 && byp_cnt < BYP_MAX);
        if (start && duty_all_nz) begin
            mode = MODE_RUN;
        end else if (check) begin
            mode = MODE_CHECK;
        end else if (byp_active) begin
            mode = MODE_BYPASS;
        end else begin
            mode = MODE_OFF;
        end
    end

    // Next gate pattern for the selected mode
    always_comb begin
        logic any_leg_fault;
        logic lower_ready;
        logic upper_ready;
        logic [CW-1:0] slot_lo;
        logic [CW-1:0] slot_hi;

        gate_nxt      = '0;
        any_leg_fault = |leg_fault;
        lower_ready   = 1'b1;
        upper_ready   = 1'b1;
        slot_lo       = '0;
        slot_hi       = '0;
        for (int unsigned i = 0; i < NLEG; i++) begin
            if (!col[2*i])   upper_ready = 1'b0;
            if (!col[2*i+1]) lower_ready = 1'b0;
        end

        case (mode)
            MODE_RUN: begin
                for (int unsigned i = 0; i < NLEG; i++) begin
                    gate_nxt[2*i]   = (dcnt[i] == DT_MAX);
                    gate_nxt[2*i+1] = (dcnt[i] == '0);
                end
            end
            MODE_CHECK: begin
                for (int unsigned k = 0; k < 2*NLEG; k++) begin
                    slot_lo = CW'(k * CHK_SLOT);
                    slot_hi = CW'(k * CHK_SLOT + CHK_ON);
                    gate_nxt[k] = (check_data >= slot_lo) && (check_data <= slot_hi)
                                  && col[k ^ 1];
                end
            end
            MODE_BYPASS: begin
                for (int unsigned i = 0; i < NLEG; i++) begin
                    if (!any_leg_fault && lower_ready) begin
                        gate_nxt[2*i] = 1'b1;
                    end else begin
                        gate_nxt[2*i+1] = !any_leg_fault && upper_ready;
                    end
                end
            end
            default: begin
                gate_nxt = '0;
            end
        endcase
    end

    // Registered gate drive; async reset drops every gate at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate <= '0;
        end else begin
            gate <= gate_nxt;
        end
    end

endmodule
